// File: rtl/aig_sweep_compactor.sv
// Exhaustive sweep driver and response compactor for a combinational benchmark:
// drives every input vector, streams (vector, response) records and folds responses into a MISR.
module aig_sweep_compactor #(
   parameter int               N_IN  = 5,
   parameter int               N_OUT = 12,
   parameter int               SIG_W = 16,
   parameter logic [SIG_W-1:0] POLY  = 16'h1021,
   parameter logic [SIG_W-1:0] SEED  = 16'hFFFF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [N_IN-1:0]  x_out,
   input  logic [N_OUT-1:0] f_in,
   output logic             rec_valid,
   input  logic             rec_ready,
   output logic [N_IN-1:0]  rec_vec,
   output logic [N_OUT-1:0] rec_resp,
   output logic             busy,
   output logic             done,
   output logic [SIG_W-1:0] signature
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   // One extra counter bit keeps the terminal compare free of wrap-around.
   localparam logic [N_IN:0] CNT_LAST = {1'b0, {N_IN{1'b1}}};

   state_t             r_state;
   state_t             w_state_nxt;
   logic [N_IN:0]      r_cnt;
   logic               r_rec_valid;
   logic [N_IN-1:0]    r_rec_vec;
   logic [N_OUT-1:0]   r_rec_resp;
   logic [SIG_W-1:0]   r_sig;
   logic               w_cap;
   logic               w_last;
   logic               w_start_ok;

   function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                  input logic [N_OUT-1:0] f);
      logic [SIG_W-1:0] fb;
      fb = s[SIG_W-1] ? POLY : '0;
      return {s[SIG_W-2:0], 1'b0} ^ fb ^ SIG_W'(f);
   endfunction

   assign w_cap      = !r_rec_valid || rec_ready;
   assign w_last     = (r_cnt == CNT_LAST);
   assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start_ok) w_state_nxt = S_RUN;
         S_RUN:   if (w_cap && w_last) w_state_nxt = S_DRAIN;
         S_DRAIN: if (rec_ready) w_state_nxt = S_DONE;
         S_DONE:  if (w_start_ok) w_state_nxt = S_RUN;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Capture stage: x_out is the low bits of cnt, so the response seen here belongs to cnt.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_rec_valid <= 1'b0;
         r_rec_vec   <= '0;
         r_rec_resp  <= '0;
         r_sig       <= SEED;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_start_ok) begin
                  r_cnt <= '0;
                  r_sig <= SEED;
               end
            end
            S_RUN: begin
               if (w_cap) begin
                  r_rec_vec   <= r_cnt[N_IN-1:0];
                  r_rec_resp  <= f_in;
                  r_rec_valid <= 1'b1;
                  r_sig       <= misr_step(r_sig, f_in);
                  if (!w_last) r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DRAIN: begin
               if (rec_ready) r_rec_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign x_out     = r_cnt[N_IN-1:0];
   assign rec_valid = r_rec_valid;
   assign rec_vec   = r_rec_vec;
   assign rec_resp  = r_rec_resp;
   assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign done      = (r_state == S_DONE);
   assign signature = r_sig;

endmodule

// File: tb/tb_aig_sweep_compactor.sv
// Directed bench: small loopback sweep with backpressure, all-zero default sweep,
// default-seed sweep with mid-sweep reset and restart from DONE.
module tb_aig_sweep_compactor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Instance A: N_IN=2, SEED=0, f = zero-extended x
   logic        rst_a, st_a, rdy_a, vld_a, busy_a, done_a;
   logic [1:0]  x_a, vec_a;
   logic [11:0] f_a, resp_a;
   logic [15:0] sig_a;
   assign f_a = {10'b0, x_a};

   aig_sweep_compactor #(.N_IN(2), .SEED(16'h0000)) dut_a (
      .clk(clk), .rst(rst_a), .start(st_a), .x_out(x_a), .f_in(f_a),
      .rec_valid(vld_a), .rec_ready(rdy_a), .rec_vec(vec_a), .rec_resp(resp_a),
      .busy(busy_a), .done(done_a), .signature(sig_a));

   // Instance C: N_IN=5, SEED=0, f tied to 0
   logic        rst_c, st_c, rdy_c, vld_c, busy_c, done_c;
   logic [4:0]  x_c, vec_c;
   logic [11:0] f_c, resp_c;
   logic [15:0] sig_c;
   assign f_c = 12'h000;

   aig_sweep_compactor #(.SEED(16'h0000)) dut_c (
      .clk(clk), .rst(rst_c), .start(st_c), .x_out(x_c), .f_in(f_c),
      .rec_valid(vld_c), .rec_ready(rdy_c), .rec_vec(vec_c), .rec_resp(resp_c),
      .busy(busy_c), .done(done_c), .signature(sig_c));

   // Instance B: default parameters, f = zero-extended x
   logic        rst_b, st_b, rdy_b, vld_b, busy_b, done_b;
   logic [4:0]  x_b, vec_b;
   logic [11:0] f_b, resp_b;
   logic [15:0] sig_b;
   assign f_b = {7'b0, x_b};

   aig_sweep_compactor dut_b (
      .clk(clk), .rst(rst_b), .start(st_b), .x_out(x_b), .f_in(f_b),
      .rec_valid(vld_b), .rec_ready(rdy_b), .rec_vec(vec_b), .rec_resp(resp_b),
      .busy(busy_b), .done(done_b), .signature(sig_b));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference signature of a 32-vector loopback sweep from seed FFFF, poly 1021.
   function automatic logic [15:0] ref_sig_b();
      logic [15:0] s;
      s = 16'hFFFF;
      for (int i = 0; i < 32; i++)
         s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ 16'(i);
      return s;
   endfunction

   logic [15:0] exp_b;

   initial begin
      exp_b = ref_sig_b();
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      st_a = 1'b0; st_b = 1'b0; st_c = 1'b0;
      rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;
      repeat (2) @(negedge clk);

      check("b_rst_x",    32'(x_b), 0);
      check("b_rst_vld",  32'(vld_b), 0);
      check("b_rst_vec",  32'(vec_b), 0);
      check("b_rst_resp", 32'(resp_b), 0);
      check("b_rst_busy", 32'(busy_b), 0);
      check("b_rst_done", 32'(done_b), 0);
      check("b_rst_sig",  32'(sig_b), 32'hFFFF);
      check("a_rst_sig",  32'(sig_a), 0);
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      @(negedge clk);
      check("a_idle_vld", 32'(vld_a), 0);

      // A: loopback, ready high
      st_a = 1'b1; @(negedge clk); st_a = 1'b0;
      check("a_start_busy", 32'(busy_a), 1);
      check("a_start_vld",  32'(vld_a), 0);
      check("a_start_x",    32'(x_a), 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("a_rec_vld",  32'(vld_a), 1);
         check("a_rec_vec",  32'(vec_a), k);
         check("a_rec_resp", 32'(resp_a), k);
         check("a_rec_x",    32'(x_a), (k < 3) ? k + 1 : 3);
      end
      check("a_drain_busy", 32'(busy_a), 1);
      check("a_drain_done", 32'(done_a), 0);
      @(negedge clk);
      check("a_done",      32'(done_a), 1);
      check("a_done_busy", 32'(busy_a), 0);
      check("a_done_vld",  32'(vld_a), 0);
      check("a_done_sig",  32'(sig_a), 32'h0003);

      // A: restart from DONE with backpressure on record 1
      st_a = 1'b1; @(negedge clk); st_a = 1'b0;
      check("a_re_sig",  32'(sig_a), 0);
      check("a_re_done", 32'(done_a), 0);
      @(negedge clk);
      check("a_bp_vec0", 32'(vec_a), 0);
      @(negedge clk);
      check("a_bp_vec1", 32'(vec_a), 1);
      rdy_a = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("a_stall_vld",  32'(vld_a), 1);
         check("a_stall_vec",  32'(vec_a), 1);
         check("a_stall_resp", 32'(resp_a), 1);
         check("a_stall_x",    32'(x_a), 2);
      end
      rdy_a = 1'b1;
      @(negedge clk);
      check("a_bp_vec2",  32'(vec_a), 2);
      check("a_bp_resp2", 32'(resp_a), 2);
      @(negedge clk);
      check("a_bp_vec3",  32'(vec_a), 3);
      @(negedge clk);
      check("a_bp_done", 32'(done_a), 1);
      check("a_bp_sig",  32'(sig_a), 32'h0003);

      // A: start pulses in RUN and in DRAIN are ignored
      st_a = 1'b1; @(negedge clk); st_a = 1'b0;
      @(negedge clk);
      check("a_ig_vec0", 32'(vec_a), 0);
      st_a = 1'b1; @(negedge clk); st_a = 1'b0;
      check("a_ig_vec1", 32'(vec_a), 1);
      check("a_ig_x1",   32'(x_a), 2);
      @(negedge clk);
      check("a_ig_vec2", 32'(vec_a), 2);
      @(negedge clk);
      check("a_ig_vec3", 32'(vec_a), 3);
      rdy_a = 1'b0; st_a = 1'b1;
      @(negedge clk);
      st_a = 1'b0;
      check("a_ig_drain_vld",  32'(vld_a), 1);
      check("a_ig_drain_busy", 32'(busy_a), 1);
      check("a_ig_drain_vec",  32'(vec_a), 3);
      rdy_a = 1'b1;
      @(negedge clk);
      check("a_ig_done", 32'(done_a), 1);
      check("a_ig_sig",  32'(sig_a), 32'h0003);
      @(negedge clk);
      check("a_ig_novld", 32'(vld_a), 0);
      check("a_ig_hold",  32'(done_a), 1);

      // C: default width, f = 0, seed 0
      st_c = 1'b1; @(negedge clk); st_c = 1'b0;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         check("c_rec_vld",  32'(vld_c), 1);
         check("c_rec_vec",  32'(vec_c), k);
         check("c_rec_resp", 32'(resp_c), 0);
      end
      @(negedge clk);
      check("c_done",     32'(done_c), 1);
      check("c_done_sig", 32'(sig_c), 0);
      check("c_done_x",   32'(x_c), 31);

      // B: reset at cnt=10
      st_b = 1'b1; @(negedge clk); st_b = 1'b0;
      repeat (10) @(negedge clk);
      check("b_mid_x", 32'(x_b), 10);
      rst_b = 1'b1; @(negedge clk); rst_b = 1'b0;
      check("b_mr_x",    32'(x_b), 0);
      check("b_mr_vld",  32'(vld_b), 0);
      check("b_mr_busy", 32'(busy_b), 0);
      check("b_mr_done", 32'(done_b), 0);
      check("b_mr_sig",  32'(sig_b), 32'hFFFF);
      @(negedge clk);
      check("b_mr_idle_vld", 32'(vld_b), 0);

      // B: full sweep, then restart from DONE
      for (int pass = 0; pass < 2; pass++) begin
         st_b = 1'b1; @(negedge clk); st_b = 1'b0;
         check("b_sw_seed", 32'(sig_b), 32'hFFFF);
         check("b_sw_done", 32'(done_b), 0);
         for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            check("b_sw_vld",  32'(vld_b), 1);
            check("b_sw_vec",  32'(vec_b), k);
            check("b_sw_resp", 32'(resp_b), k);
         end
         @(negedge clk);
         check("b_sw_fin_done", 32'(done_b), 1);
         check("b_sw_fin_sig",  32'(sig_b), 32'(exp_b));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/aig_sweep_compactor.md
Name: aig_sweep_compactor

Overview:
- Exhaustive stimulus/response stage wrapped around one generated combinational benchmark (5 inputs x0..x4, 12 outputs f1..f12).
- Upstream half: sweeps every input vector 0..2^N_IN-1 onto the benchmark inputs.
- Downstream half: captures each response, streams (vector, response) records to the dataset writer over valid/ready, and folds responses into a MISR signature for golden-model comparison.

Parameters:
- N_IN, 5, benchmark input count; sweep length 2^N_IN.
- N_OUT, 12, benchmark output count; must satisfy N_OUT <= SIG_W.
- SIG_W, 16, MISR width.
- POLY, 16'h1021, MISR feedback polynomial (low SIG_W bits used).
- SEED, 16'hFFFF, MISR value at reset and at each start.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin sweep; honoured only in IDLE or DONE.
- x_out  out  N_IN  vector driven to benchmark inputs (bit0 = x0).
- f_in  in  N_OUT  benchmark response (bit0 = f1); combinational from x_out, same cycle.
- rec_valid  out  1  record available.
- rec_ready  in  1  downstream accepts record.
- rec_vec  out  N_IN  vector of current record.
- rec_resp  out  N_OUT  response of current record.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; held until next start or rst.
- signature  out  SIG_W  MISR value; final once done=1.

Behaviour:
- Reset (rst=1 at edge) has priority over every other input, including mid-sweep. Reset values:
  - state = IDLE, x_out = 0, cnt = 0
  - rec_valid = 0, rec_vec = 0, rec_resp = 0
  - busy = 0, done = 0, signature = SEED
- In-flight records are discarded on reset. No record is emitted after reset until a new start.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start: cnt = 0, x_out = 0, signature = SEED, done = 0, next state RUN. rec_valid is already 0 in both states.
- start in RUN/DRAIN: ignored.
- RUN, capture condition: cap = (rec_valid==0) || rec_ready.
- RUN, on cap, all at the same edge:
  - rec_vec <= cnt, rec_resp <= f_in, rec_valid <= 1
  - signature <= {signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1] ? POLY : 0) ^ zero-extend(f_in)
  - if cnt == 2^N_IN-1: state <= DRAIN, x_out holds. Otherwise cnt <= cnt+1 and x_out <= cnt+1.
- RUN, no cap (rec_valid && !rec_ready): x_out, cnt, signature and record hold. No vector is skipped or duplicated.
- Throughput: one vector per cycle with rec_ready held high. The first record is valid in the cycle after the start edge. The last record is valid 2^N_IN cycles after the start edge.
- rec_valid de-asserts only when a record is accepted and no new capture occurs. Once asserted, rec_vec and rec_resp are stable until handshake (rec_valid && rec_ready).
- DRAIN: on handshake of the final record, rec_valid <= 0 and state <= DONE. busy is still 1 in DRAIN.
- DONE: done = 1, busy = 0; signature holds. A new start restarts the sweep.
- cnt is N_IN+1 bits internally to avoid wrap. x_out never wraps past 2^N_IN-1 within a sweep.
- Exactly 2^N_IN records per sweep, rec_vec strictly ascending 0..2^N_IN-1.

Test Plan:
- Loopback (f_in = zero-extended x_out), N_IN=2, SEED=0, rec_ready=1:
  - start -> records (0,0),(1,1),(2,2),(3,3) on 4 consecutive cycles.
  - done rises 1 cycle after the last handshake.
  - signature = 16'h0003.
- Default params, f_in tied 0, SEED=0, rec_ready=1 -> 32 records, rec_vec 0..31, rec_resp = 0, signature = 16'h0000, done=1.
- Backpressure, N_IN=2 loopback, SEED=0, rec_ready low for 3 cycles on record 1:
  - x_out holds 2 during the stall.
  - rec_vec/rec_resp hold 1/1.
  - Final signature still 16'h0003 and no record lost.
- start pulsed while busy in RUN and again in DRAIN -> ignored; sweep completes normally with exactly 2^N_IN records.
- rst asserted mid-sweep at cnt=10 -> next cycle:
  - state IDLE, x_out=0, rec_valid=0, busy=0, done=0, signature=SEED.
  - A subsequent start gives a full, correct sweep.
- Restart from DONE: second start -> signature reset to SEED; identical final signature to the first sweep for the same f_in function.
